// File: rtl/usb_wire_tx_serializer_if.sv
// Transmit-byte-processor to wire-serializer symbol handshake.
interface usb_wire_tx_serializer_if;
    logic [1:0] USBWireData;
    logic       USBWireCtrl;
    logic       USBWireWEn;
    logic       USBWireRdy;

    modport master (
        output USBWireData,
        output USBWireCtrl,
        output USBWireWEn,
        input  USBWireRdy
    );

    modport slave (
        input  USBWireData,
        input  USBWireCtrl,
        input  USBWireWEn,
        output USBWireRdy
    );
endinterface

// File: rtl/usb_wire_tx_serializer.sv
// USB SIE bit-rate output stage: symbol FIFO drained one entry per bit period.
// Optional low-speed rate selection is built when USB_WIRE_TX_LOWSPEED_EN is defined.
module usb_wire_tx_serializer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FS_DIV     = 4,
    parameter int unsigned LS_DIV     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    usb_wire_tx_serializer_if.slave  wire_if,
    input  logic                     fullSpeedRate,
    output logic [1:0]               TxWireDataOut,
    output logic                     TxWireOE,
    output logic                     TxIdle
);
    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
`ifdef USB_WIRE_TX_LOWSPEED_EN
    localparam int unsigned DIV_MAX = (LS_DIV > FS_DIV) ? LS_DIV : FS_DIV;
`else
    localparam int unsigned DIV_MAX = FS_DIV;
`endif
    localparam int unsigned DIV_W = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    logic [2:0]       mem_q [FIFO_DEPTH];
    logic [2:0]       rd_entry;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] div_last;
    logic [1:0]       data_q, data_d;
    logic             oe_q, oe_d;
    logic             idle_q, idle_d;
    logic             push, pop, tick;

`ifdef USB_WIRE_TX_LOWSPEED_EN
    logic rate_q, rate_d;
    assign div_last = rate_q ? DIV_W'(FS_DIV - 1) : DIV_W'(LS_DIV - 1);
`else
    logic unused_rate;
    assign unused_rate = fullSpeedRate;
    assign div_last    = DIV_W'(FS_DIV - 1);
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wire_if.USBWireRdy = (count_q != PTR_W'(FIFO_DEPTH));
    assign push     = wire_if.USBWireWEn && wire_if.USBWireRdy;
    assign tick     = (div_q == div_last);
    assign pop      = tick && (count_q != '0);
    assign rd_entry = mem_q[rd_ptr_q[IDX_W-1:0]];

    assign TxWireDataOut = data_q;
    assign TxWireOE      = oe_q;
    assign TxIdle        = idle_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        oe_d     = oe_q;
        idle_d   = idle_q;
        div_d    = tick ? '0 : div_q + 1'b1;
`ifdef USB_WIRE_TX_LOWSPEED_EN
        rate_d   = rate_q;
        // Rate only changes at a bit boundary while idle, so div_q is 0 when div_last moves.
        if (tick && idle_q) rate_d = fullSpeedRate;
`endif
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            data_d   = rd_entry[1:0];
            oe_d     = rd_entry[2];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A push always wins over the empty-tick set, even on the same cycle.
        if (push)                          idle_d = 1'b0;
        else if (tick && count_q == '0)    idle_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[IDX_W-1:0]] <= {wire_if.USBWireCtrl, wire_if.USBWireData};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            div_q    <= '0;
            data_q   <= '0;
            oe_q     <= 1'b0;
            idle_q   <= 1'b1;
`ifdef USB_WIRE_TX_LOWSPEED_EN
            rate_q   <= 1'b1;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            div_q    <= div_d;
            data_q   <= data_d;
            oe_q     <= oe_d;
            idle_q   <= idle_d;
`ifdef USB_WIRE_TX_LOWSPEED_EN
            rate_q   <= rate_d;
`endif
        end
    end
endmodule
